mult_seq_param: RTL and testbench

MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

---
 rtl/mult_seq_param.sv | 139 +++++++++++++
 tb/tb_mult_seq_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
// rtl/mult_seq_param.sv - sequential shift/add multiplier, unsigned or two's-complement operands
module mult_seq_param #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic           abort,
  input  logic           signed_mode,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic           done,
  output logic           op_add,
  output logic           op_sub,
  output logic           op_shift
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t        state;
  logic [W-1:0]  m_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          x_reg;
  logic [CW-1:0] cnt;
  logic          mode;

  logic [W:0]    ext_a;
  logic [W:0]    ext_m;
  logic [W:0]    alu;
  logic [CW-1:0] cnt_next;
  logic          last_step;
  logic          next_is_sub;

  // The sign bit of the multiplier carries negative weight, so its partial
  // product is subtracted on the final step when operands are signed.
  assign ext_a       = {mode & a_reg[W-1], a_reg};
  assign ext_m       = {mode & m_reg[W-1], m_reg};
  assign last_step   = (cnt == LAST);
  assign alu         = (mode && last_step) ? (ext_a - ext_m) : (ext_a + ext_m);
  assign cnt_next    = cnt + 1'b1;
  assign next_is_sub = mode && (cnt_next == LAST);
  assign product     = {a_reg, b_reg};

  // Control FSM and datapath; outputs are registered alongside the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      m_reg    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      x_reg    <= 1'b0;
      cnt      <= '0;
      mode     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      op_add   <= 1'b0;
      op_sub   <= 1'b0;
      op_shift <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      x_reg    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      op_add   <= 1'b0;
      op_sub   <= 1'b0;
      op_shift <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            m_reg <= a_in;
            b_reg <= b_in;
            a_reg <= '0;
            x_reg <= 1'b0;
            cnt   <= '0;
            mode  <= signed_mode;
            busy  <= 1'b1;
            // cnt starts at 0, which is never the last step since W >= 2
            if (b_in[0]) begin
              state  <= ADD;
              op_add <= 1'b1;
            end else begin
              state    <= SHIFT;
              op_shift <= 1'b1;
            end
          end
        end
        ADD: begin
          {x_reg, a_reg} <= alu;
          state          <= SHIFT;
          op_add         <= 1'b0;
          op_sub         <= 1'b0;
          op_shift       <= 1'b1;
        end
        SHIFT: begin
          x_reg <= mode & x_reg;
          a_reg <= {x_reg, a_reg[W-1:1]};
          b_reg <= {a_reg[0], b_reg[W-1:1]};
          cnt   <= cnt_next;
          if (last_step) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            op_shift <= 1'b0;
          end else if (b_reg[1]) begin
            state    <= ADD;
            op_shift <= 1'b0;
            op_add   <= !next_is_sub;
            op_sub   <= next_is_sub;
          end
        end
        DONE: begin
          if (!run) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          op_add   <= 1'b0;
          op_sub   <= 1'b0;
          op_shift <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// tb/tb_mult_seq_param.sv - scoreboard bench for mult_seq_param at W=4, 8 and 16
module tb_mult_seq_param;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          adds;
    int          subs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        signed_mode;
  logic [15:0] a_drv;
  logic [15:0] b_drv;
  logic [2:0]  run_v;
  logic [2:0]  abort_v;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [2:0]  busy_v, done_v, add_v, sub_v, shift_v;

  logic [1:0]  sel;
  logic [31:0] prod_s;
  logic        busy_s, done_s, add_s, sub_s, shift_s;

  exp_t        sb[$];
  logic [31:0] cur_b;
  logic [31:0] last_prod;
  int          last_lat, last_adds, last_subs;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mult_seq_param #(.W(4)) u4 (
    .clk(clk), .reset(reset), .run(run_v[0]), .abort(abort_v[0]), .signed_mode(signed_mode),
    .a_in(a_drv[3:0]), .b_in(b_drv[3:0]), .product(p4), .busy(busy_v[0]), .done(done_v[0]),
    .op_add(add_v[0]), .op_sub(sub_v[0]), .op_shift(shift_v[0]));

  mult_seq_param #(.W(8)) u8 (
    .clk(clk), .reset(reset), .run(run_v[1]), .abort(abort_v[1]), .signed_mode(signed_mode),
    .a_in(a_drv[7:0]), .b_in(b_drv[7:0]), .product(p8), .busy(busy_v[1]), .done(done_v[1]),
    .op_add(add_v[1]), .op_sub(sub_v[1]), .op_shift(shift_v[1]));

  mult_seq_param #(.W(16)) u16 (
    .clk(clk), .reset(reset), .run(run_v[2]), .abort(abort_v[2]), .signed_mode(signed_mode),
    .a_in(a_drv), .b_in(b_drv), .product(p16), .busy(busy_v[2]), .done(done_v[2]),
    .op_add(add_v[2]), .op_sub(sub_v[2]), .op_shift(shift_v[2]));

  // Route the instance under test onto a common set of observation signals
  always_comb begin
    prod_s  = p16;
    busy_s  = busy_v[2];
    done_s  = done_v[2];
    add_s   = add_v[2];
    sub_s   = sub_v[2];
    shift_s = shift_v[2];
    if (sel == 2'd0) begin
      prod_s = {24'b0, p4};
      busy_s = busy_v[0]; done_s = done_v[0]; add_s = add_v[0]; sub_s = sub_v[0]; shift_s = shift_v[0];
    end else if (sel == 2'd1) begin
      prod_s = {16'b0, p8};
      busy_s = busy_v[1]; done_s = done_v[1]; add_s = add_v[1]; sub_s = sub_v[1]; shift_s = shift_v[1];
    end
  end

  function automatic int wof(input logic [1:0] s);
    return (s == 2'd0) ? 4 : ((s == 2'd1) ? 8 : 16);
  endfunction

  function automatic exp_t model(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint wm   = (longint'(1) << w) - 1;
    longint mask = (longint'(1) << (2 * w)) - 1;
    longint ua   = longint'(a) & wm;
    longint ub   = longint'(b) & wm;
    longint sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
    longint sbv  = ub[w-1] ? ub - (longint'(1) << w) : ub;
    longint p    = sm ? sa * sbv : ua * ub;
    e.prod = 32'(p & mask);
    e.lat  = w + $countones(ub);
    e.subs = (sm && ub[w-1]) ? 1 : 0;
    e.adds = $countones(ub) - e.subs;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op(input logic [1:0] s, input logic sm, input logic [15:0] a, input logic [15:0] b);
    int w;
    w           = wof(s);
    sel         = s;
    signed_mode = sm;
    a_drv       = a;
    b_drv       = b;
    run_v[s]    = 1'b1;
    cur_b       = {16'b0, b} & ((32'd1 << w) - 32'd1);
    sb.push_back(model(w, sm, a, b));
  endtask

  task automatic finish_op(input string tag, input bit hold_run);
    int   n;
    int   adds;
    int   subs;
    int   sub_pos;
    exp_t e;
    n = 0; adds = 0; subs = 0; sub_pos = -1;
    step();
    check({tag, ":load"}, prod_s, cur_b);
    check({tag, ":busy"}, 32'(busy_s), 32'd1);
    if (!hold_run) run_v[sel] = 1'b0;
    a_drv       = 16'($urandom);
    b_drv       = 16'($urandom);
    signed_mode = 1'($urandom);
    while (!done_s && n < 100) begin
      if (add_s) adds++;
      if (sub_s) begin
        subs++;
        sub_pos = n;
      end
      check({tag, ":onehot"}, 32'($countones({add_s, sub_s, shift_s})), 32'd1);
      step();
      n++;
    end
    if (sb.size() == 0) begin
      check({tag, ":sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, ":lat"}, 32'(n), 32'(e.lat));
    check({tag, ":prod"}, prod_s, e.prod);
    check({tag, ":done"}, 32'(done_s), 32'd1);
    check({tag, ":idle_ops"}, {28'b0, busy_s, add_s, sub_s, shift_s}, 32'd0);
    check({tag, ":adds"}, 32'(adds), 32'(e.adds));
    check({tag, ":subs"}, 32'(subs), 32'(e.subs));
    if (e.subs != 0) check({tag, ":sub_pos"}, 32'(sub_pos), 32'(e.lat - 2));
    last_prod = prod_s;
    last_lat  = n;
    last_adds = adds;
    last_subs = subs;
    if (hold_run) begin
      repeat (3) step();
      check({tag, ":hold_done"}, 32'(done_s), 32'd1);
      check({tag, ":hold_prod"}, prod_s, e.prod);
      run_v[sel] = 1'b0;
    end
    step();
    check({tag, ":back_idle"}, {30'b0, done_s, busy_s}, 32'd0);
    check({tag, ":idle_prod"}, prod_s, e.prod);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run_v = '0; abort_v = '0; signed_mode = 1'b0;
    a_drv = '0; b_drv = '0; sel = 2'd1;
    step(); step();
    check("rst_prod8", prod_s, 32'd0);
    check("rst_flags8", {27'b0, busy_s, done_s, add_s, sub_s, shift_s}, 32'd0);
    sel = 2'd2;
    check("rst_prod16", prod_s, 32'd0);

    // Reset beats run; run held across reset release starts immediately
    begin_op(2'd1, 1'b0, 16'h07, 16'h3B);
    step();
    check("rst_beats_run", {31'b0, busy_s}, 32'd0);
    reset = 1'b0;
    finish_op("r30", 1'b0);
    check("r30_prod_const", last_prod, 32'h019D);
    check("r30_lat_const", 32'(last_lat), 32'd13);

    begin_op(2'd1, 1'b0, 16'hFF, 16'hFF);
    finish_op("r31u", 1'b0);
    check("r31u_prod_const", last_prod, 32'hFE01);
    check("r31u_lat_const", 32'(last_lat), 32'd16);

    begin_op(2'd1, 1'b1, 16'hFF, 16'hFF);
    finish_op("r31s", 1'b0);
    check("r31s_prod_const", last_prod, 32'h0001);
    check("r31s_subs_const", 32'(last_subs), 32'd1);

    begin_op(2'd1, 1'b1, 16'h80, 16'h80);
    finish_op("r32", 1'b0);
    check("r32_prod_const", last_prod, 32'h4000);
    check("r32_subs_const", 32'(last_subs), 32'd1);

    begin_op(2'd1, 1'b0, 16'hA5, 16'h00);
    finish_op("r33", 1'b0);
    check("r33_lat_const", 32'(last_lat), 32'd8);
    check("r33_prod_const", last_prod, 32'd0);
    check("r33_adds_const", 32'(last_adds), 32'd0);

    // run held through DONE, then released and raised again on the next cycle
    begin_op(2'd1, 1'b1, 16'h93, 16'h6D);
    finish_op("hold", 1'b1);
    begin_op(2'd1, 1'b0, 16'h07, 16'h3B);
    finish_op("restart", 1'b0);
    check("restart_prod_const", last_prod, 32'h019D);

    // Abort at cnt=3 with a non-zero partial result in flight
    begin_op(2'd1, 1'b0, 16'hFF, 16'hF0);
    step();
    run_v[1] = 1'b0;
    repeat (3) step();
    check("abort_partial", prod_s, 32'h001E);
    abort_v[1] = 1'b1;
    step();
    abort_v[1] = 1'b0;
    check("abort_prod", prod_s, 32'd0);
    check("abort_flags", {27'b0, busy_s, done_s, add_s, sub_s, shift_s}, 32'd0);
    void'(sb.pop_front());
    step();
    check("abort_stays_idle", {31'b0, busy_s}, 32'd0);

    // Reset at cnt=3
    begin_op(2'd1, 1'b0, 16'hFF, 16'hF0);
    step();
    run_v[1] = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_mid_prod", prod_s, 32'd0);
    check("reset_mid_flags", {27'b0, busy_s, done_s, add_s, sub_s, shift_s}, 32'd0);
    void'(sb.pop_front());

    // Abort beats run in the same cycle
    begin_op(2'd1, 1'b1, 16'h55, 16'h33);
    abort_v[1] = 1'b1;
    step();
    check("abort_beats_run", {31'b0, busy_s}, 32'd0);
    abort_v[1] = 1'b0;
    finish_op("after_abort", 1'b0);

    // Boundary patterns at W=4 and W=16 against the model
    for (int s = 0; s < 3; s += 2) begin
      begin_op(2'(s), 1'b0, 16'hFFFF, 16'hFFFF);
      finish_op("ones_u", 1'b0);
      begin_op(2'(s), 1'b1, 16'hFFFF, 16'hFFFF);
      finish_op("ones_s", 1'b0);
      begin_op(2'(s), 1'b1, (s == 0) ? 16'h0008 : 16'h8000, (s == 0) ? 16'h0008 : 16'h8000);
      finish_op("min_s", 1'b0);
      begin_op(2'(s), 1'b0, 16'h5A5A, 16'h0000);
      finish_op("zero_b", 1'b0);
    end

    for (int i = 0; i < 1000; i++) begin
      begin_op(2'd0, 1'($urandom), 16'($urandom), 16'($urandom));
      finish_op("rnd4", 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      begin_op(2'd2, 1'($urandom), 16'($urandom), 16'($urandom));
      finish_op("rnd16", 1'b0);
    end
    for (int i = 0; i < 100; i++) begin
      begin_op(2'd1, 1'($urandom), 16'($urandom), 16'($urandom));
      finish_op("rnd8", 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
